// File: rtl/uart_matrix_cfg_pkg.sv
// Shared constants, state encoding and helpers for the matrix LUT
// configuration controller.
package uart_matrix_cfg_pkg;

  localparam logic [7:0] CFG_HDR = 8'hA5;
  localparam logic [7:0] CFG_ACK = 8'h06;
  localparam logic [7:0] CFG_NAK = 8'h15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ROW  = 2'd1,
    ST_MASK = 2'd2,
    ST_SUM  = 2'd3
  } cfg_state_t;

  // Error counter increment that sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_matrix_cfg_idle_timer.sv
// Inter-byte idle timer: counts while enabled, restarts on clear, and
// pulses expired once the frame has stalled for timeout cycles.
module cfg_idle_timer #(
  parameter int timeout = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(timeout + 1);
  localparam logic [W-1:0] LAST = W'(timeout - 1);

  logic [W-1:0] count;

  // Count k-1 is held during the k-th idle cycle after the last byte.
  assign expired = en && (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr || !en || expired) begin
      count <= '0;
    end else begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/uart_matrix_cfg.sv
// Parses A5/row/mask/sum route commands from the control UART and writes
// the matrix routing LUT, answering each frame with ACK or NAK.
module uart_matrix_cfg
  import uart_matrix_cfg_pkg::*;
#(
  parameter int m       = 8,
  parameter int n       = 8,
  parameter int timeout = 100000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   rx_data,
  input  logic         rx_stb,
  input  logic         ack_full,
  output logic [m-1:0] lut_addr,
  output logic [n-1:0] lut_data,
  output logic         lut_cke,
  output logic [7:0]   ack_data,
  output logic         ack_cke,
  output logic         busy,
  output logic [7:0]   err_cnt
);

  localparam int B  = (n + 7) / 8;
  localparam int MW = 8 * B;
  localparam int AW = m;
  localparam int CW = (B > 1) ? $clog2(B) : 1;
  localparam logic [CW-1:0] LAST_BYTE = CW'(B - 1);

  cfg_state_t    state;
  logic [7:0]    row_reg;
  logic [7:0]    xor_reg;
  logic [MW-1:0] mask_reg;
  logic [MW-1:0] mask_shift;
  logic [CW-1:0] byte_cnt;
  logic [7:0]    xor_next;
  logic          row_ok;
  logic          expired;

  assign busy     = (state != ST_IDLE);
  assign xor_next = xor_reg ^ rx_data;
  assign row_ok   = ({24'd0, row_reg} < 32'(m));

  // Bytes arrive little-endian, so each new byte enters at the top.
  generate
    if (B == 1) begin : g_mask_one
      assign mask_shift = rx_data;
    end else begin : g_mask_multi
      assign mask_shift = {rx_data, mask_reg[MW-1:8]};
    end
  endgenerate

  cfg_idle_timer #(
    .timeout (timeout)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (rx_stb),
    .en      (busy),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      row_reg  <= '0;
      xor_reg  <= '0;
      mask_reg <= '0;
      byte_cnt <= '0;
      lut_addr <= '0;
      lut_data <= '0;
      lut_cke  <= 1'b0;
      ack_data <= '0;
      ack_cke  <= 1'b0;
      err_cnt  <= '0;
    end else begin
      lut_cke <= 1'b0;
      ack_cke <= 1'b0;
      if (expired) begin
        // Abandon the stalled frame; a coincident byte is seen by IDLE.
        err_cnt <= sat_inc8(err_cnt);
        state   <= ST_IDLE;
        if (rx_stb && rx_data == CFG_HDR) begin
          state   <= ST_ROW;
          xor_reg <= '0;
        end
      end else if (rx_stb) begin
        case (state)
          ST_IDLE: begin
            if (rx_data == CFG_HDR) begin
              state   <= ST_ROW;
              xor_reg <= '0;
            end
          end
          ST_ROW: begin
            row_reg  <= rx_data;
            xor_reg  <= rx_data;
            byte_cnt <= '0;
            state    <= ST_MASK;
          end
          ST_MASK: begin
            mask_reg <= mask_shift;
            xor_reg  <= xor_next;
            if (byte_cnt == LAST_BYTE) begin
              state <= ST_SUM;
            end else begin
              byte_cnt <= byte_cnt + CW'(1);
            end
          end
          ST_SUM: begin
            state   <= ST_IDLE;
            ack_cke <= !ack_full;
            if (row_ok && rx_data == xor_reg) begin
              lut_addr <= AW'(row_reg);
              lut_data <= mask_reg[n-1:0];
              lut_cke  <= 1'b1;
              ack_data <= CFG_ACK;
            end else begin
              ack_data <= CFG_NAK;
              err_cnt  <= sat_inc8(err_cnt);
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_matrix_cfg.sv
// Bench for uart_matrix_cfg: an n=8 and an n=12 instance, table-driven
// frames with a response scoreboard, plus timeout/reset/back-to-back cases.
module tb_uart_matrix_cfg;

  localparam int TMO = 20;

  typedef struct {
    logic        lut;
    logic [7:0]  addr;
    logic [11:0] data;
    logic        ack;
    logic [7:0]  code;
  } exp_t;

  typedef struct {
    int          sel;
    int          len;
    logic [63:0] b;
    logic        full;
    exp_t        e;
    logic [7:0]  err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        stb_a = 1'b0;
  logic        stb_b = 1'b0;
  logic        ack_full = 1'b0;

  logic [7:0]  lut_addr_a, ack_data_a, err_a;
  logic [7:0]  lut_data_a;
  logic        lut_cke_a, ack_cke_a, busy_a;
  logic [7:0]  lut_addr_b, ack_data_b, err_b;
  logic [11:0] lut_data_b;
  logic        lut_cke_b, ack_cke_b, busy_b;

  int total = 0;
  int bad = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  vec_t vec[7];

  always #5 clk = ~clk;

  uart_matrix_cfg #(.m(8), .n(8), .timeout(TMO)) dut_a (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_stb(stb_a), .ack_full(ack_full),
    .lut_addr(lut_addr_a), .lut_data(lut_data_a), .lut_cke(lut_cke_a),
    .ack_data(ack_data_a), .ack_cke(ack_cke_a), .busy(busy_a), .err_cnt(err_a)
  );

  uart_matrix_cfg #(.m(8), .n(12), .timeout(TMO)) dut_b (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_stb(stb_b), .ack_full(ack_full),
    .lut_addr(lut_addr_b), .lut_data(lut_data_b), .lut_cke(lut_cke_b),
    .ack_data(ack_data_b), .ack_cke(ack_cke_b), .busy(busy_b), .err_cnt(err_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, want);
    end
  endtask

  task automatic check_out(input string tag, input exp_t e, input logic lut,
                           input logic [7:0] addr, input logic [11:0] data,
                           input logic ack, input logic [7:0] code);
    chk({tag, "_lut_cke"}, 32'(lut), 32'(e.lut));
    if (e.lut) begin
      chk({tag, "_lut_addr"}, 32'(addr), 32'(e.addr));
      chk({tag, "_lut_data"}, 32'(data), 32'(e.data));
    end
    chk({tag, "_ack_cke"}, 32'(ack), 32'(e.ack));
    if (e.ack) chk({tag, "_ack_data"}, 32'(code), 32'(e.code));
    $display("resp %s lut=%0b addr=%0h data=%0h ack=%0b code=%0h", tag, lut, addr, data, ack, code);
  endtask

  always @(negedge clk) begin
    if (!rst && (lut_cke_a || ack_cke_a)) begin
      if (q_a.size() == 0) begin
        total++; bad++;
        $display("FAIL out_a unexpected lut_cke=%0b ack_cke=%0b want none", lut_cke_a, ack_cke_a);
      end else begin
        check_out("a", q_a.pop_front(), lut_cke_a, lut_addr_a, {4'h0, lut_data_a}, ack_cke_a, ack_data_a);
      end
    end
    if (!rst && (lut_cke_b || ack_cke_b)) begin
      if (q_b.size() == 0) begin
        total++; bad++;
        $display("FAIL out_b unexpected lut_cke=%0b ack_cke=%0b want none", lut_cke_b, ack_cke_b);
      end else begin
        check_out("b", q_b.pop_front(), lut_cke_b, lut_addr_b, lut_data_b, ack_cke_b, ack_data_b);
      end
    end
  end

  // Bytes go out on consecutive clocks, first byte in the most significant slot.
  task automatic send(input int sel, input int len, input logic [63:0] b, input logic full);
    ack_full = full;
    @(posedge clk); #1;
    for (int i = 0; i < len; i++) begin
      rx_data = b[8*(len-1-i) +: 8];
      stb_a = (sel == 0);
      stb_b = (sel == 1);
      @(posedge clk); #1;
    end
    stb_a = 1'b0;
    stb_b = 1'b0;
  endtask

  task automatic check_zero_a(input string tag);
    chk({tag, "_lut_addr"}, 32'(lut_addr_a), 0);
    chk({tag, "_lut_data"}, 32'(lut_data_a), 0);
    chk({tag, "_lut_cke"}, 32'(lut_cke_a), 0);
    chk({tag, "_ack_data"}, 32'(ack_data_a), 0);
    chk({tag, "_ack_cke"}, 32'(ack_cke_a), 0);
    chk({tag, "_busy"}, 32'(busy_a), 0);
    chk({tag, "_err"}, 32'(err_a), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0] = '{0, 4, 64'hA503F0F3,   1'b0, '{1'b1, 8'h03, 12'h0F0, 1'b1, 8'h06}, 8'd0};
    vec[1] = '{0, 4, 64'hA503F000,   1'b0, '{1'b0, 8'h00, 12'h000, 1'b1, 8'h15}, 8'd1};
    vec[2] = '{0, 4, 64'hA5090108,   1'b0, '{1'b0, 8'h00, 12'h000, 1'b1, 8'h15}, 8'd2};
    vec[3] = '{1, 5, 64'hA50134F2C7, 1'b0, '{1'b1, 8'h01, 12'h234, 1'b1, 8'h06}, 8'd0};
    vec[4] = '{1, 5, 64'hA50134F2C7, 1'b1, '{1'b1, 8'h01, 12'h234, 1'b0, 8'h00}, 8'd0};
    vec[5] = '{0, 4, 64'hA5078087,   1'b0, '{1'b1, 8'h07, 12'h080, 1'b1, 8'h06}, 8'd2};
    vec[6] = '{0, 4, 64'hA5088088,   1'b0, '{1'b0, 8'h00, 12'h000, 1'b1, 8'h15}, 8'd3};

    // Reset state of both instances.
    @(negedge clk);
    check_zero_a("rst_a");
    chk("rst_b_lut_data", 32'(lut_data_b), 0);
    chk("rst_b_busy", 32'(busy_b), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      if (vec[i].sel == 0) q_a.push_back(vec[i].e);
      else q_b.push_back(vec[i].e);
      $display("frame %0d dut=%0d bytes=%0h ack_full=%0b", i, vec[i].sel, vec[i].b, vec[i].full);
      send(vec[i].sel, vec[i].len, vec[i].b, vec[i].full);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_err", i), 32'(vec[i].sel == 0 ? err_a : err_b), 32'(vec[i].err));
      chk($sformatf("v%0d_busy", i), 32'(vec[i].sel == 0 ? busy_a : busy_b), 0);
      ack_full = 1'b0;
    end

    // Rejected frame left the last written row untouched.
    chk("hold_addr", 32'(lut_addr_a), 32'h07);
    chk("hold_data", 32'(lut_data_a), 32'h80);

    // Stray bytes in IDLE: silent, never busy.
    $display("stray bytes 11 22");
    send(0, 1, 64'h11, 1'b0);
    @(negedge clk);
    chk("stray1_busy", 32'(busy_a), 0);
    send(0, 1, 64'h22, 1'b0);
    @(negedge clk);
    chk("stray2_busy", 32'(busy_a), 0);
    chk("stray_err", 32'(err_a), 3);

    // Stall mid-frame until the timer fires.
    $display("timeout after A5 03");
    send(0, 2, 64'hA503, 1'b0);
    repeat (TMO - 1) @(posedge clk);
    @(negedge clk);
    chk("tmo_busy_before", 32'(busy_a), 1);
    @(posedge clk);
    @(negedge clk);
    chk("tmo_busy_after", 32'(busy_a), 0);
    chk("tmo_err", 32'(err_a), 4);
    q_a.push_back('{1'b1, 8'h02, 12'h00F, 1'b1, 8'h06});
    $display("frame after timeout A5 02 0F 0D");
    send(0, 4, 64'hA5020F0D, 1'b0);
    repeat (2) @(posedge clk);

    // New header lands in the response cycle of the previous frame.
    q_a.push_back('{1'b1, 8'h03, 12'h0F0, 1'b1, 8'h06});
    q_a.push_back('{1'b1, 8'h04, 12'h00F, 1'b1, 8'h06});
    $display("back-to-back frames A5 03 F0 F3 A5 04 0F 0B");
    send(0, 8, 64'hA503F0F3A5040F0B, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("b2b_err", 32'(err_a), 4);

    // Reset in the middle of a frame.
    $display("reset after A5 05");
    send(0, 2, 64'hA505, 1'b0);
    rst = 1'b1;
    #1;
    check_zero_a("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    q_a.push_back('{1'b1, 8'h05, 12'h0FF, 1'b1, 8'h06});
    $display("frame after reset A5 05 FF FA");
    send(0, 4, 64'hA505FFFA, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("post_rst_err", 32'(err_a), 0);
    chk("post_rst_addr", 32'(lut_addr_a), 32'h05);
    chk("q_a_empty", 32'(q_a.size()), 0);
    chk("q_b_empty", 32'(q_b.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
